// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch front end: default address and instruction
// widths, the fetch-address default after reset, and the {pc, instr} record
// carried from instruction memory towards decode.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] RESET_PC = '0;

  // One fetched instruction together with the address it was read from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/instr_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue_if
// Bundles the prefetch queue's memory, redirect and decode-side signals.
//   imem_addr/imem_data       : combinational instruction memory read port
//   redirect_valid/redirect_pc: flush-and-restart request from branch resolution
//   pf_valid/pf_ready         : valid/ready handshake towards decode
//   pf_pc/pf_instr/pf_count   : head entry and current occupancy
// Modports:
//   master : the prefetch queue (drives imem_addr and the pf_* head outputs)
//   slave  : the surrounding core (memory, branch unit, decode)
// -----------------------------------------------------------------------------
interface instr_prefetch_queue_if #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int CNT_W   = 3
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               pf_valid;
  logic               pf_ready;
  logic [PC_W-1:0]    pf_pc;
  logic [INSTR_W-1:0] pf_instr;
  logic [CNT_W-1:0]   pf_count;

  modport master (
    output imem_addr, pf_valid, pf_pc, pf_instr, pf_count,
    input  imem_data, redirect_valid, redirect_pc, pf_ready
  );

  modport slave (
    input  imem_addr, pf_valid, pf_pc, pf_instr, pf_count,
    output imem_data, redirect_valid, redirect_pc, pf_ready
  );

endinterface : instr_prefetch_queue_if

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Synchronous first-word-fall-through FIFO: the oldest entry is always visible
// on rd_data while count != 0. flush empties the FIFO in one cycle.
//   clk, rst : clock; synchronous active-high reset
//   push     : write wr_data this cycle (caller guarantees !full or pop)
//   pop      : retire the head entry this cycle (caller guarantees count != 0)
//   flush    : discard all entries; overrides push and pop
//   wr_data  : entry written on push
//   rd_data  : head entry
//   count    : occupancy, 0..DEPTH
//   full     : count == DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // NOTE: the storage array has no reset; entries are only observable after
  // a push, so clearing them would only add reset fan-out to a RAM-like array.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // here samples the pre-edge values of the others, independent of ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));

endmodule : sync_fifo_fwft

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
// Sequential instruction prefetcher. fetch_pc drives a combinational
// instruction memory; each cycle with room in the queue the {pc, instr} pair
// is pushed and fetch_pc advances. Decode drains the head over pf_valid /
// pf_ready. A redirect flushes the queue and restarts fetch at redirect_pc.
//   clk : system clock
//   rst : synchronous active-high reset; overrides redirect and push
//   bus : instr_prefetch_queue_if master (imem port, redirect, decode handshake)
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter int              INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_prefetch_queue_if.master  bus
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = PC_W + INSTR_W;

  logic [PC_W-1:0]    fetch_pc;
  logic               push;
  logic               pop;
  logic               full;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;

  // Redirect blocks both sides: the head is discarded rather than handed to
  // decode, and the instruction at the stale fetch_pc is not enqueued.
  assign pop  = bus.pf_valid & bus.pf_ready & ~bus.redirect_valid;
  // A full queue can still accept when the head leaves in the same cycle.
  assign push = ~bus.redirect_valid & (~full | pop);

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (bus.redirect_valid),
    .wr_data ({fetch_pc, bus.imem_data}),
    .rd_data (head),
    .count   (count),
    .full    (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_W'(1);
    end
  end

  // imem_addr comes straight from a register, so it only moves on clock edges.
  assign bus.imem_addr = fetch_pc;
  assign bus.pf_valid  = (count != '0);
  assign bus.pf_pc     = head[ENTRY_W-1 -: PC_W];
  assign bus.pf_instr  = head[INSTR_W-1:0];
  assign bus.pf_count  = count;

endmodule : instr_prefetch_queue

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
// Self-checking bench for instr_prefetch_queue (DEPTH=4, PC_W=16, INSTR_W=32).
// Instruction memory model: imem[a] = 0x1000_0000 + a. A scoreboard queue of
// expected {pc, instr} records is reloaded on every reset or redirect and is
// popped on every decode handshake.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  instr_prefetch_queue_if #(.PC_W(16), .INSTR_W(32), .CNT_W(CNT_W)) bus ();

  instr_prefetch_queue #(
    .DEPTH    (DEPTH),
    .PC_W     (16),
    .INSTR_W  (32),
    .RESET_PC (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.imem_data = 32'h1000_0000 + 32'(bus.imem_addr);

  int checks     = 0;
  int failures   = 0;
  int handshakes = 0;

  fetch_entry_t exp_q[$];

  typedef struct {
    logic        rst;
    logic        redir;
    logic [15:0] redir_pc;
    logic        ready;
    logic        exp_valid;
    logic [2:0]  exp_count;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_exp(input logic [15:0] base);
    fetch_entry_t e;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc    = base + 16'(i);
      e.instr = 32'h1000_0000 + 32'(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Evaluate the handshake on the stable pre-edge values, then advance one
  // clock and settle past the edge.
  task automatic tick();
    fetch_entry_t e;
    if (rst) begin
      load_exp(16'h0000);
    end else if (bus.redirect_valid) begin
      load_exp(bus.redirect_pc);
    end else if (bus.pf_valid && bus.pf_ready) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: got pc %0h expected no delivery", bus.pf_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 64'(bus.pf_pc), 64'(e.pc));
        check("sb_instr", 64'(bus.pf_instr), 64'(e.instr));
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic d, input logic [15:0] dpc,
                              input logic rdy, input logic v, input logic [2:0] c,
                              input logic [15:0] a, input logic [15:0] p);
    vec_t t;
    t.rst = r; t.redir = d; t.redir_pc = dpc; t.ready = rdy;
    t.exp_valid = v; t.exp_count = c; t.exp_addr = a; t.exp_pc = p;
    return t;
  endfunction

  int hs0;

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    bus.pf_ready       = 1'b0;

    //              rst   redir  rpc       rdy   valid cnt   addr      head pc
    tbl[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000); // reset
    tbl[1]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 16'h0001, 16'h0000); // first push
    tbl[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h0002, 16'h0000);
    tbl[3]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'h0003, 16'h0000);
    tbl[4]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'h0004, 16'h0000); // full
    tbl[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'h0004, 16'h0000); // hold
    tbl[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd4, 16'h0005, 16'h0001); // full + pop
    tbl[7]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'h0005, 16'h0001);
    tbl[8]  = mk(1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, 3'd0, 16'h000C, 16'h0000); // redirect
    tbl[9]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h000D, 16'h000C);
    tbl[10] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h000E, 16'h000D);
    tbl[11] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h000F, 16'h000E);
    tbl[12] = mk(1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 3'd0, 16'hFFFE, 16'h0000); // wrap redirect
    tbl[13] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'hFFFF, 16'hFFFE);
    tbl[14] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0000, 16'hFFFF);
    tbl[15] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0001, 16'h0000);
    tbl[16] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0002, 16'h0001);
    tbl[17] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h0003, 16'h0001);
    tbl[18] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'h0004, 16'h0001);
    tbl[19] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'h0005, 16'h0001); // full
    tbl[20] = mk(1'b1, 1'b1, 16'h0055, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000); // rst + redirect
    tbl[21] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0001, 16'h0000);
    tbl[22] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0002, 16'h0001);

    // Table-driven walk: back-pressure, full+pop, redirects, wrap, mid-stream reset.
    for (int i = 0; i < 23; i++) begin
      rst                = tbl[i].rst;
      bus.redirect_valid = tbl[i].redir;
      bus.redirect_pc    = tbl[i].redir_pc;
      bus.pf_ready       = tbl[i].ready;
      tick();
      check($sformatf("v%0d_valid", i), 64'(bus.pf_valid), 64'(tbl[i].exp_valid));
      check($sformatf("v%0d_count", i), 64'(bus.pf_count), 64'(tbl[i].exp_count));
      check($sformatf("v%0d_addr", i),  64'(bus.imem_addr), 64'(tbl[i].exp_addr));
      if (tbl[i].exp_valid)
        check($sformatf("v%0d_pc", i), 64'(bus.pf_pc), 64'(tbl[i].exp_pc));
    end
    bus.redirect_valid = 1'b0;

    // Reset then stream with decode always ready: one instruction per cycle.
    rst = 1'b1; bus.pf_ready = 1'b1;
    tick();
    check("stream_rst_valid", 64'(bus.pf_valid), 64'(1'b0));
    rst = 1'b0;
    hs0 = handshakes;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stream_valid", 64'(bus.pf_valid), 64'(1'b1));
      check("stream_count", 64'(bus.pf_count), 64'(1));
    end
    check("stream_handshakes", 64'(handshakes - hs0), 64'(19));

    // Back-pressure for 10 cycles, then release: pc 0..7 with no gap.
    rst = 1'b1; bus.pf_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("bp_count", 64'(bus.pf_count), 64'(4));
    check("bp_addr", 64'(bus.imem_addr), 64'(16'h0004));
    check("bp_head_pc", 64'(bus.pf_pc), 64'(16'h0000));
    check("bp_head_instr", 64'(bus.pf_instr), 64'(32'h1000_0000));
    bus.pf_ready = 1'b1;
    hs0 = handshakes;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bp_release_valid", 64'(bus.pf_valid), 64'(1'b1));
    end
    check("bp_release_handshakes", 64'(handshakes - hs0), 64'(8));

    // Redirect with the queue half full and decode ready.
    rst = 1'b1; bus.pf_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("half_count", 64'(bus.pf_count), 64'(2));
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h000C; bus.pf_ready = 1'b1;
    tick();
    check("redir_valid", 64'(bus.pf_valid), 64'(1'b0));
    check("redir_count", 64'(bus.pf_count), 64'(0));
    check("redir_addr", 64'(bus.imem_addr), 64'(16'h000C));
    bus.redirect_valid = 1'b0;
    tick();
    check("redir_first_valid", 64'(bus.pf_valid), 64'(1'b1));
    check("redir_first_pc", 64'(bus.pf_pc), 64'(16'h000C));
    tick();
    check("redir_second_pc", 64'(bus.pf_pc), 64'(16'h000D));
    check("redir_second_instr", 64'(bus.pf_instr), 64'(32'h1000_000D));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_prefetch_queue

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch queue between the instruction memory and the decode stage. It runs a sequential fetch PC against the combinational instruction memory and buffers up to DEPTH fetched {pc, instr} pairs. It hands them to decode over a valid/ready handshake, which decouples memory reads from decode back-pressure. A redirect from the branch-resolution path flushes the queue and restarts fetch at the target.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- PC_W, 16: fetch address width; word-addressed.
- INSTR_W, 32: instruction word width.
- RESET_PC, 0: fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_addr  out  PC_W  instruction memory read address; equals the fetch_pc register.
- imem_data  in  INSTR_W  instruction memory read data; combinational from imem_addr in the same cycle.
- redirect_valid  in  1  flush the queue and restart fetch.
- redirect_pc  in  PC_W  restart address; sampled when redirect_valid=1.
- pf_valid  out  1  head entry is valid.
- pf_ready  in  1  decode accepts the head entry (dec_ready).
- pf_pc  out  PC_W  PC of the head entry.
- pf_instr  out  INSTR_W  instruction of the head entry.
- pf_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State:
  - fetch_pc register.
  - DEPTH-entry circular buffer of {pc, instr}.
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- pop = pf_valid & pf_ready & ~redirect_valid.
- push = ~redirect_valid & ((count < DEPTH) | pop). A full queue with a same-cycle pop still accepts a push.
- On push: write {fetch_pc, imem_data} at wr_ptr, increment wr_ptr, and set fetch_pc <= fetch_pc + 1.
- fetch_pc arithmetic is modulo 2^PC_W, so 0xFFFF wraps to 0x0000.
- On pop: increment rd_ptr.
- Count update: count <= count + push - pop.
- Head output is first-word-fall-through:
  - pf_valid = (count != 0).
  - pf_pc and pf_instr are read from the buffer at rd_ptr.
  - pf_pc and pf_instr hold their values while pf_valid=1 and pf_ready=0.
- Redirect has priority over everything. In the redirect cycle:
  - rd_ptr, wr_ptr and count go to 0.
  - fetch_pc <= redirect_pc.
  - No push and no pop occur, even if pf_ready=1; the head entry is discarded.
- Reset (rst=1 at the edge):
  - fetch_pc = RESET_PC; pointers and count = 0.
  - Outputs after the edge: pf_valid=0, pf_count=0, imem_addr=RESET_PC.
  - Buffer contents are don't-care.
  - Reset asserted mid-stream overrides both push and redirect.
- pf_valid=0 with pf_ready=1 is legal and has no effect.

## Timing
- One instruction fetched per cycle while not full.
- First instruction visible one cycle after the reset edge. The first non-reset edge pushes RESET_PC, so pf_valid=1 in the following cycle.
- Redirect-to-valid latency is 2 edges: the redirect edge loads fetch_pc, the next edge pushes the target instruction, and pf_valid rises after it.
- The queue fills to DEPTH in DEPTH cycles if decode stalls. It then holds with fetch_pc = last pushed PC + 1.
- Steady-state throughput is 1 instruction per cycle with pf_ready held high. Occupancy saturates at DEPTH.
- imem_addr changes only on clock edges; there is no combinational path from pf_ready or redirect to imem_addr.

## Structure
- Shared package `cpu_pkg`:
  - PC_W and INSTR_W constants.
  - typedef `fetch_entry_t` = struct {pc, instr}.
  - RESET_PC default.
- One sub-module, `sync_fifo_fwft`, parameterised on width and depth:
  - Ports: push, pop, flush, head data, count.
  - It is reused for the fetch-to-decode path elsewhere.
- The top block holds only fetch_pc, the push/pop/redirect arbitration, and the imem hookup.

## Test plan
- Reset then stream: imem[i] = 0x1000_0000+i, pf_ready=1 → pf_valid rises one cycle after reset; pf_pc = 0,1,2,… one per cycle; pf_instr matches imem.
- Back-pressure: pf_ready=0 for 10 cycles after reset → pf_count reaches 4 at cycle 4 and holds; imem_addr = 4; the head stays pc=0. Releasing pf_ready then delivers pc 0..7 in order with no gap.
- Full plus simultaneous pop: at count=4, pf_ready=1 for one cycle → count stays 4; head advances to pc=1; the tail receives pc=4.
- Redirect: redirect_valid=1, redirect_pc=0x0C with the queue half full and pf_ready=1 → the next cycle has pf_valid=0 and count=0; two edges after the redirect, pf_pc=0x0C, and pc 0x0D follows.
- Wrap: redirect to 0xFFFE → delivered PCs are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Mid-stream reset: rst=1 for one cycle while the queue is full and redirect_valid=1 → pf_valid=0, pf_count=0, imem_addr=RESET_PC; streaming restarts from pc 0.
